// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared types and constants for the memory responder:
//               FSM state encoding, captured error-cause encoding and the
//               number of bytes per memory word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISALIGN = 2'd1,
    RANGE    = 2'd2,
    CONFLICT = 2'd3
  } err_cause_t;

endpackage : mem_if_pkg
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// Module      : word_ram
// Description : DEPTH_WORDS x 32 storage array with synchronous write and
//               registered synchronous read. The array itself is not reset;
//               only the read-data register is. The read register can be
//               cleared to 0 so error responses return zero data.
// Ports       : clk    - clock
//               reset  - asynchronous active-low reset (read register only)
//               we     - write enable (addr/wdata stored on the edge)
//               re     - read enable (rdata loaded from addr on the edge)
//               rclr   - clear read register to 0 (takes priority over re)
//               addr   - word index
//               wdata  - write data
//               rdata  - registered read data, holds between reads
// Revision    : 1.0 - initial release
// ============================================================================
module word_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic                           re,
  input  logic                           rclr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rclr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : word_ram
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder with configurable latency. Captures a
//               single read/write request, waits LATENCY cycles, performs the
//               access on an internal word array and returns a one-cycle
//               Ready strobe with Error flagging misaligned, out-of-range or
//               conflicting (read+write) requests.
// Ports       : clk        - clock
//               reset      - asynchronous active-low reset
//               MemRead    - read request level
//               MemWrite   - write request level
//               Address    - byte address (word index = Address[31:2])
//               Write_data - write data, captured with the request
//               Mem_data   - read data, held until the next read response
//               Ready      - one-cycle response strobe
//               Busy       - transaction in flight (cycle after capture
//                            through the Ready cycle)
//               Error      - error flag, meaningful only while Ready=1
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Mem_data,
  output logic        Ready,
  output logic        Busy,
  output logic        Error
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam int OFS = $clog2(WORD_BYTES);
  localparam logic [CW-1:0]     CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [31-OFS:0]   IDX_LIMIT = (32 - OFS)'(DEPTH_WORDS);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  err_cause_t    cause_q, cause_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;

  err_cause_t    req_cause;
  logic          ram_we;
  logic          ram_re;
  logic          ram_clr;

  // Error classification of the live request; conflict outranks address
  // faults, which only matters for which cause is recorded, not for Error.
  always_comb begin
    req_cause = NONE;
    if (MemRead && MemWrite) begin
      req_cause = CONFLICT;
    end else if (Address[OFS-1:0] != '0) begin
      req_cause = MISALIGN;
    end else if (Address[31:OFS] >= IDX_LIMIT) begin
      req_cause = RANGE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cause_d = cause_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    ram_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          idx_d   = Address[OFS +: AW];
          wdata_d = Write_data;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          cause_d = req_cause;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Access happens on the edge into RESP so the registered read
          // data and the Ready strobe appear together.
          state_d = RESP;
          ready_d = 1'b1;
          error_d = (cause_q != NONE);
          if (cause_q == NONE) begin
            ram_we = wr_q;
            ram_re = rd_q;
          end else begin
            // Faulted reads (including read+write conflicts) return zero.
            ram_clr = rd_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cause_q <= NONE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cause_q <= cause_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_word_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .rclr (ram_clr),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(Mem_data)
  );

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Error = error_q;

endmodule : mem_responder
`default_nettype wire
